// File: rtl/dash_ctrl.sv
// Dashboard control core: keypad events drive power, lamps, gear interlock and a chaser/hazard blink engine.
// Optional build macro DASH_TURN_TIMEOUT_EN adds auto-cancel of the turn signal after TURN_TIMEOUT chaser cycles.
module dash_ctrl #(
  parameter int KEY_W          = 4,
  parameter int LAMPS_PER_SIDE = 3,
  parameter int BLINK_DIV      = 25000000,
  parameter int TURN_TIMEOUT   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [KEY_W-1:0]            key_code,
  input  logic                        key_valid,
  output logic                        power_on,
  output logic                        headlights,
  output logic [2*LAMPS_PER_SIDE-1:0] dir,
  output logic                        brake_light,
  output logic [1:0]                  gear,
  output logic                        reverse_light,
  output logic                        shift_reject
);
  localparam int L      = LAMPS_PER_SIDE;
  localparam int CNT_W  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int STEP_W = (L > 1) ? $clog2(L + 1) : 1;

  localparam logic [KEY_W-1:0] K_POWER = KEY_W'(5);
  localparam logic [KEY_W-1:0] K_HEAD  = KEY_W'(8);
  localparam logic [KEY_W-1:0] K_LEFT  = KEY_W'(4);
  localparam logic [KEY_W-1:0] K_RIGHT = KEY_W'(6);
  localparam logic [KEY_W-1:0] K_HAZ   = KEY_W'(7);
  localparam logic [KEY_W-1:0] K_BRAKE = KEY_W'(15);
  localparam logic [KEY_W-1:0] K_P     = KEY_W'(1);
  localparam logic [KEY_W-1:0] K_R     = KEY_W'(2);
  localparam logic [KEY_W-1:0] K_N     = KEY_W'(3);
  localparam logic [KEY_W-1:0] K_D     = KEY_W'(10);

  localparam logic [1:0] GEAR_P = 2'b00;
  localparam logic [1:0] GEAR_R = 2'b01;
  localparam logic [1:0] GEAR_N = 2'b10;
  localparam logic [1:0] GEAR_D = 2'b11;

  typedef enum logic {PWR_OFF, PWR_ON} pwr_e;
  typedef enum logic [1:0] {TURN_NONE, TURN_LEFT, TURN_RIGHT} turn_e;
  typedef enum logic [1:0] {MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZ} mode_e;

  if (LAMPS_PER_SIDE < 1 || BLINK_DIV < 2 || TURN_TIMEOUT < 1) begin : g_bad_param
    $error("dash_ctrl: parameter out of range");
  end

  pwr_e              pwr_q, pwr_d;
  turn_e             turn_q, turn_d;
  mode_e             mode_q, mode_d;
  logic              head_q, head_d, haz_q, haz_d, brake_q, brake_d, rej_q, rej_d;
  logic [1:0]        gear_q, gear_d, gear_tgt;
  logic              gear_req, turn_key, wrap_now;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
`ifdef DASH_TURN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TURN_TIMEOUT + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwr_q   <= PWR_OFF;
      turn_q  <= TURN_NONE;
      mode_q  <= MODE_IDLE;
      head_q  <= 1'b0;
      haz_q   <= 1'b0;
      brake_q <= 1'b0;
      rej_q   <= 1'b0;
      gear_q  <= GEAR_P;
      cnt_q   <= '0;
      step_q  <= '0;
`ifdef DASH_TURN_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      pwr_q   <= pwr_d;
      turn_q  <= turn_d;
      mode_q  <= mode_d;
      head_q  <= head_d;
      haz_q   <= haz_d;
      brake_q <= brake_d;
      rej_q   <= rej_d;
      gear_q  <= gear_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
`ifdef DASH_TURN_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    pwr_d    = pwr_q;
    turn_d   = turn_q;
    mode_d   = mode_q;
    head_d   = head_q;
    haz_d    = haz_q;
    brake_d  = brake_q;
    rej_d    = 1'b0;
    gear_d   = gear_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    gear_req = 1'b0;
    gear_tgt = gear_q;
    turn_key = 1'b0;
    wrap_now = (mode_q != MODE_IDLE) && (cnt_q == CNT_W'(BLINK_DIV - 1)) &&
               (step_q == STEP_W'(L));
`ifdef DASH_TURN_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    if (key_valid) begin
      if (pwr_q == PWR_OFF) begin
        if (key_code == K_POWER) pwr_d = PWR_ON;
      end else begin
        case (key_code)
          K_POWER: begin
            if (gear_q == GEAR_P) begin
              pwr_d   = PWR_OFF;
              head_d  = 1'b0;
              turn_d  = TURN_NONE;
              haz_d   = 1'b0;
              brake_d = 1'b0;
            end else begin
              rej_d = 1'b1;
            end
          end
          K_HEAD:  head_d  = ~head_q;
          K_HAZ:   haz_d   = ~haz_q;
          K_BRAKE: brake_d = ~brake_q;
          K_LEFT: begin
            turn_key = 1'b1;
            turn_d   = (turn_q == TURN_LEFT) ? TURN_NONE : TURN_LEFT;
          end
          K_RIGHT: begin
            turn_key = 1'b1;
            turn_d   = (turn_q == TURN_RIGHT) ? TURN_NONE : TURN_RIGHT;
          end
          K_P: begin gear_req = 1'b1; gear_tgt = GEAR_P; end
          K_R: begin gear_req = 1'b1; gear_tgt = GEAR_R; end
          K_N: begin gear_req = 1'b1; gear_tgt = GEAR_N; end
          K_D: begin gear_req = 1'b1; gear_tgt = GEAR_D; end
          default: ;
        endcase
      end
    end

    // Leaving P needs the brake; D and R never swap directly.
    if (gear_req && gear_tgt != gear_q) begin
      if (gear_q == GEAR_P && !brake_q) rej_d = 1'b1;
      else if ((gear_q == GEAR_D && gear_tgt == GEAR_R) ||
               (gear_q == GEAR_R && gear_tgt == GEAR_D)) rej_d = 1'b1;
      else gear_d = gear_tgt;
    end

`ifdef DASH_TURN_TIMEOUT_EN
    // A turn key pressed on the expiry cycle wins over the timeout.
    if (pwr_d == PWR_OFF || turn_key) begin
      tmo_d = '0;
    end else if (wrap_now && turn_q != TURN_NONE) begin
      if (tmo_q == TMO_W'(TURN_TIMEOUT - 1)) begin
        tmo_d  = '0;
        turn_d = TURN_NONE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    if (pwr_d == PWR_OFF) mode_d = MODE_IDLE;
    else if (haz_d)       mode_d = MODE_HAZ;
    else if (turn_d == TURN_LEFT)  mode_d = MODE_LEFT;
    else if (turn_d == TURN_RIGHT) mode_d = MODE_RIGHT;
    else mode_d = MODE_IDLE;

    // Any change of display mode restarts the engine with the first lamp lit.
    if (mode_d == MODE_IDLE) begin
      cnt_d  = '0;
      step_d = '0;
    end else if (mode_d != mode_q) begin
      cnt_d  = '0;
      step_d = STEP_W'(1);
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d  = '0;
      step_d = (step_q == STEP_W'(L)) ? '0 : step_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    dir = '0;
    for (int i = 0; i < L; i++) begin
      case (mode_q)
        MODE_LEFT:  dir[L+i] = int'(step_q) > i;
        MODE_RIGHT: dir[i]   = int'(step_q) > i;
        MODE_HAZ: begin
          dir[i]   = step_q[0];
          dir[L+i] = step_q[0];
        end
        default: ;
      endcase
    end
  end

  assign power_on      = (pwr_q == PWR_ON);
  assign headlights    = head_q;
  assign brake_light   = power_on & brake_q;
  assign gear          = gear_q;
  assign reverse_light = power_on & (gear_q == GEAR_R);
  assign shift_reject  = rej_q;

endmodule
